wb_openram_arbiter: RTL



---
 rtl/wb_openram_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/wb_openram_arbiter.sv
// Two-master Wishbone arbiter sharing the RW port 0 of an OpenRAM macro (IDLE/CMD/DATA/ACK sequencer).
// Define OPENRAM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (master 0 wins).
module wb_openram_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs0_stb_i,
  input  logic                  wbs0_cyc_i,
  input  logic                  wbs0_we_i,
  input  logic [3:0]            wbs0_sel_i,
  input  logic [31:0]           wbs0_dat_i,
  input  logic [31:0]           wbs0_adr_i,
  output logic                  wbs0_ack_o,
  output logic [31:0]           wbs0_dat_o,
  input  logic                  wbs1_stb_i,
  input  logic                  wbs1_cyc_i,
  input  logic                  wbs1_we_i,
  input  logic [3:0]            wbs1_sel_i,
  input  logic [31:0]           wbs1_dat_i,
  input  logic [31:0]           wbs1_adr_i,
  output logic                  wbs1_ack_o,
  output logic [31:0]           wbs1_dat_o,
  output logic                  ram_clk0,
  output logic                  ram_csb0,
  output logic                  ram_web0,
  output logic [3:0]            ram_wmask0,
  output logic [ADDR_WIDTH-1:0] ram_addr0,
  output logic [31:0]           ram_din0,
  input  logic [31:0]           ram_dout0
);

  localparam int unsigned TAG_LSB = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  we_q, we_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           din_q, din_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [31:0]           dat0_q, dat0_d;
  logic [31:0]           dat1_q, dat1_d;
`ifndef OPENRAM_ARB_FIXED_PRIO_EN
  logic                  last_grant_q, last_grant_d;
`endif

  logic                  hit0_c, hit1_c, req0_c, req1_c, grant_c;
  logic                  gnt_we_c;
  logic [3:0]            gnt_sel_c;
  logic [31:0]           gnt_dat_c;
  logic [ADDR_WIDTH-1:0] gnt_word_c;
  logic                  unused_adr_bits;

  // Byte-offset bits never reach the word-addressed RAM.
  assign unused_adr_bits = ^{wbs0_adr_i[1:0], wbs1_adr_i[1:0]};

  assign hit0_c = (wbs0_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign hit1_c = (wbs1_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign req0_c = wbs0_cyc_i & wbs0_stb_i & hit0_c;
  assign req1_c = wbs1_cyc_i & wbs1_stb_i & hit1_c;

  // Grant selection; only meaningful when at least one request is present.
  always_comb begin
`ifdef OPENRAM_ARB_FIXED_PRIO_EN
    grant_c = !req0_c;
`else
    grant_c = req0_c ? (req1_c && !last_grant_q) : 1'b1;
`endif
    gnt_we_c   = grant_c ? wbs1_we_i  : wbs0_we_i;
    gnt_sel_c  = grant_c ? wbs1_sel_i : wbs0_sel_i;
    gnt_dat_c  = grant_c ? wbs1_dat_i : wbs0_dat_i;
    gnt_word_c = grant_c ? wbs1_adr_i[TAG_LSB-1:2] : wbs0_adr_i[TAG_LSB-1:2];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    csb_d   = csb_q;
    web_d   = web_q;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    dat0_d  = dat0_q;
    dat1_d  = dat1_q;
`ifndef OPENRAM_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req0_c || req1_c) begin
          state_d = ST_CMD;
          grant_d = grant_c;
          we_d    = gnt_we_c;
          csb_d   = 1'b0;
          web_d   = !gnt_we_c;
          wmask_d = gnt_we_c ? gnt_sel_c : 4'h0;
          addr_d  = gnt_word_c;
          din_d   = gnt_dat_c;
`ifndef OPENRAM_ARB_FIXED_PRIO_EN
          last_grant_d = grant_c;
`endif
        end
      end
      ST_CMD: begin
        state_d = ST_DATA;
        csb_d   = 1'b1;
        web_d   = 1'b1;
        wmask_d = 4'h0;
      end
      ST_DATA: begin
        // An aborted cycle still finishes the RAM access but gets no ack.
        state_d = ST_ACK;
        if (!we_q) begin
          if (grant_q) dat1_d = ram_dout0;
          else         dat0_d = ram_dout0;
        end
        ack0_d = !grant_q && wbs0_cyc_i;
        ack1_d = grant_q && wbs1_cyc_i;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      we_q    <= 1'b0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= 4'h0;
      addr_q  <= '0;
      din_q   <= 32'h0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      dat0_q  <= 32'h0;
      dat1_q  <= 32'h0;
`ifndef OPENRAM_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      dat0_q  <= dat0_d;
      dat1_q  <= dat1_d;
`ifndef OPENRAM_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign ram_clk0   = wb_clk_i;
  assign ram_csb0   = csb_q;
  assign ram_web0   = web_q;
  assign ram_wmask0 = wmask_q;
  assign ram_addr0  = addr_q;
  assign ram_din0   = din_q;
  assign wbs0_ack_o = ack0_q;
  assign wbs0_dat_o = dat0_q;
  assign wbs1_ack_o = ack1_q;
  assign wbs1_dat_o = dat1_q;

endmodule
